// File: rtl/pkt_rewrite_mux.sv
// Two-stage byte-stream rewriter: replaces MAC addresses, decrements the IPv4
// TTL with an incremental checksum fix-up, and counts modified packets.
module pkt_rewrite_mux #(
  parameter int MAX_OFS = 2047
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  input  logic        in_sop,
  input  logic        act_dmac_en,
  input  logic [47:0] act_dmac,
  input  logic        act_smac_en,
  input  logic [47:0] act_smac,
  input  logic        act_ttl_dec,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic [15:0] stat_rewr_cnt
);

  localparam int OW = (MAX_OFS > 0) ? $clog2(MAX_OFS + 1) : 1;
  typedef logic [OW-1:0] ofs_t;
  localparam ofs_t OFS_MAX = ofs_t'(MAX_OFS);

  // Handshake: a byte moves across a port only on a cycle where valid and
  // ready are both high; out_* never change while out_valid && !out_ready.

  ofs_t        ofs_q, ofs_d;
  logic        dmac_en_q, dmac_en_d, smac_en_q, smac_en_d, ttl_dec_q, ttl_dec_d;
  logic [47:0] dmac_q, dmac_d, smac_q, smac_d;
  logic        b12_q, b12_d, is_ip_q, is_ip_d, ttl_mod_q, ttl_mod_d, mod_q, mod_d;
  logic        a_valid_q, a_valid_d, a_last_q, a_last_d, a_cks_q, a_cks_d, a_mod_q, a_mod_d;
  logic [7:0]  a_data_q, a_data_d;
  logic        out_valid_q, out_valid_d, out_last_q, out_last_d, out_mod_q, out_mod_d;
  logic [7:0]  out_data_q, out_data_d;
  logic [15:0] cnt_q, cnt_d;

  logic        advance, in_fire, a_move, sop_take;
  logic        rw_hit, ttl_hit;
  logic [7:0]  rw_data, b_data;
  logic [16:0] cks_sum;
  logic [15:0] cks_new;
  logic [47:0] mac_sh;
  int          ofs_n;

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance || !a_valid_q;
  assign in_fire  = in_valid && in_ready;
  // Checksum high byte waits in stage A until the low byte arrives.
  assign a_move   = a_valid_q && advance && !(a_cks_q && !in_fire);
  assign sop_take = in_sop && (ofs_q == '0) && !in_fire;

  assign cks_sum = {1'b0, a_data_q, in_data} + 17'h00100;
  assign cks_new = cks_sum[15:0] + {15'b0, cks_sum[16]};
  assign b_data  = (a_cks_q && ttl_mod_q) ? cks_new[15:8] : a_data_q;

  always_comb begin
    ofs_n   = int'(ofs_q);
    rw_data = in_data;
    rw_hit  = 1'b0;
    ttl_hit = 1'b0;
    mac_sh  = '0;
    if (dmac_en_q && ofs_n < 6) begin
      mac_sh  = dmac_q << (8 * ofs_n);
      rw_data = mac_sh[47:40];
      rw_hit  = 1'b1;
    end else if (smac_en_q && ofs_n >= 6 && ofs_n < 12) begin
      mac_sh  = smac_q << (8 * (ofs_n - 6));
      rw_data = mac_sh[47:40];
      rw_hit  = 1'b1;
    end else if (ofs_n == 22 && ttl_dec_q && is_ip_q && in_data != 8'h00) begin
      rw_data = in_data - 8'd1;
      rw_hit  = 1'b1;
      ttl_hit = 1'b1;
    end else if (ofs_n == 25 && a_cks_q && ttl_mod_q) begin
      rw_data = cks_new[7:0];
    end
  end

  always_comb begin
    ofs_d       = ofs_q;
    dmac_en_d   = dmac_en_q;
    dmac_d      = dmac_q;
    smac_en_d   = smac_en_q;
    smac_d      = smac_q;
    ttl_dec_d   = ttl_dec_q;
    b12_d       = b12_q;
    is_ip_d     = is_ip_q;
    ttl_mod_d   = ttl_mod_q;
    mod_d       = mod_q;
    a_valid_d   = a_valid_q;
    a_data_d    = a_data_q;
    a_last_d    = a_last_q;
    a_cks_d     = a_cks_q;
    a_mod_d     = a_mod_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_mod_d   = out_mod_q;
    cnt_d       = cnt_q;

    if (sop_take) begin
      dmac_en_d = act_dmac_en;
      dmac_d    = act_dmac;
      smac_en_d = act_smac_en;
      smac_d    = act_smac;
      ttl_dec_d = act_ttl_dec;
    end

    if (in_fire) begin
      if (in_last)               ofs_d = '0;
      else if (ofs_q != OFS_MAX) ofs_d = ofs_q + 1'b1;
      if (ofs_n == 0) begin
        b12_d     = 1'b0;
        is_ip_d   = 1'b0;
        ttl_mod_d = 1'b0;
      end
      if (ofs_n == 12) b12_d = (in_data == 8'h08);
      if (ofs_n == 13) is_ip_d = b12_q && (in_data == 8'h00);
      if (ttl_hit) ttl_mod_d = 1'b1;
      if (rw_hit) mod_d = 1'b1;
      if (in_last) begin
        b12_d     = 1'b0;
        is_ip_d   = 1'b0;
        ttl_mod_d = 1'b0;
        mod_d     = 1'b0;
      end
      a_valid_d = 1'b1;
      a_data_d  = rw_data;
      a_last_d  = in_last;
      a_cks_d   = (ofs_n == 24) && !in_last;
      a_mod_d   = in_last && (mod_q || rw_hit);
    end else if (a_move) begin
      a_valid_d = 1'b0;
      a_cks_d   = 1'b0;
    end

    if (advance) begin
      out_valid_d = a_move;
      if (a_move) begin
        out_data_d = b_data;
        out_last_d = a_last_q;
        out_mod_d  = a_mod_q;
      end
    end

    if (out_valid_q && out_ready && out_last_q && out_mod_q) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ofs_q       <= '0;
      dmac_en_q   <= 1'b0;
      dmac_q      <= '0;
      smac_en_q   <= 1'b0;
      smac_q      <= '0;
      ttl_dec_q   <= 1'b0;
      b12_q       <= 1'b0;
      is_ip_q     <= 1'b0;
      ttl_mod_q   <= 1'b0;
      mod_q       <= 1'b0;
      a_valid_q   <= 1'b0;
      a_data_q    <= '0;
      a_last_q    <= 1'b0;
      a_cks_q     <= 1'b0;
      a_mod_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_mod_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      ofs_q       <= ofs_d;
      dmac_en_q   <= dmac_en_d;
      dmac_q      <= dmac_d;
      smac_en_q   <= smac_en_d;
      smac_q      <= smac_d;
      ttl_dec_q   <= ttl_dec_d;
      b12_q       <= b12_d;
      is_ip_q     <= is_ip_d;
      ttl_mod_q   <= ttl_mod_d;
      mod_q       <= mod_d;
      a_valid_q   <= a_valid_d;
      a_data_q    <= a_data_d;
      a_last_q    <= a_last_d;
      a_cks_q     <= a_cks_d;
      a_mod_q     <= a_mod_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_mod_q   <= out_mod_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_last      = out_last_q;
  assign stat_rewr_cnt = cnt_q;

endmodule

// File: doc/pkt_rewrite_mux.md
PKT_REWRITE_MUX -- requirements
Module: pkt_rewrite_mux

Interface
REQ-001 SHALL have parameter MAX_OFS, default 2047, the saturation value of the byte-offset counter; the counter width is $clog2(MAX_OFS+1).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have ports in_valid / in_data / in_last / in_ready: input 1 / input 8 / input 1 / output 1; the byte stream from the upper packet FIFO.
REQ-005 SHALL have port in_sop, input, 1, a pulse from the upper FIFO one or more cycles before byte 0 of a packet.
REQ-006 SHALL have ports act_dmac_en, input 1, and act_dmac, input 48: rewrite of destination MAC bytes 0-5, MSB first.
REQ-007 SHALL have ports act_smac_en, input 1, and act_smac, input 48: rewrite of source MAC bytes 6-11, MSB first.
REQ-008 SHALL have port act_ttl_dec, input, 1, which requests an IPv4 TTL decrement with checksum update.
REQ-009 SHALL have ports out_valid / out_data / out_last / out_ready: output 1 / output 8 / output 1 / input 1; the rewritten stream.
REQ-010 SHALL have port stat_rewr_cnt, output, 16: count of packets with at least one modified byte; wraps at 0xFFFF->0.

Function
REQ-011 SHALL transfer a byte on in_valid&&in_ready and on out_valid&&out_ready; out_data/out_last SHALL hold stable while out_valid&&!out_ready.
REQ-012 SHALL be a two-register pipeline (stage A, stage B = out_*): latency 2 cycles, one byte per cycle sustained; the pipeline SHALL advance when !out_valid||out_ready; in_ready = advance||!a_valid.
REQ-013 SHALL latch all act_* inputs on in_sop only when ofs==0 and no byte of the current packet has been accepted; otherwise in_sop SHALL be ignored; latched actions apply to the whole packet.
REQ-014 SHALL keep ofs = offset of the next accepted byte; ofs increments per accepted byte, saturates at MAX_OFS, and clears to 0 after an accepted byte with in_last=1.
REQ-015 SHALL replace bytes 0-5 with act_dmac[47:40]..[7:0] when dmac_en is latched, and bytes 6-11 with act_smac likewise when smac_en is latched.
REQ-016 SHALL set is_ip when byte 12==0x08 and byte 13==0x00; is_ip clears at ofs 0.
REQ-017 SHALL, at byte 22, decrement the TTL when ttl_dec is latched, is_ip is set and TTL!=0; it SHALL then set ttl_mod; TTL==0 SHALL pass unchanged with ttl_mod=0.
REQ-018 SHALL, when ttl_mod is set, update the checksum (byte 24 hi, byte 25 lo) as: S = {hi,lo}+0x0100 (17 bits); new = S[15:0]+S[16], modulo 2^16.
REQ-019 SHALL hold byte 24 in stage A until byte 25 is accepted so that both checksum bytes are written from the 16-bit result; byte 24 SHALL NOT reach stage B before byte 25 enters stage A.
REQ-020 SHALL emit an unmodified byte 24 if the packet ends (in_last) at byte 24.
REQ-021 SHALL apply only the rewrites whose offsets are reached when a packet ends early (in_last before offset 25).
REQ-022 SHALL propagate in_last to out_last with its byte unchanged; packet boundaries SHALL be preserved with no bytes added or dropped.
REQ-023 SHALL increment stat_rewr_cnt once per packet, when out_last is transferred, if any of dmac/smac/ttl_mod applied.

Reset
REQ-024 SHALL, on rst_n low, asynchronously clear out_valid, out_data, out_last, stage A, ofs, the latched actions, is_ip, ttl_mod and stat_rewr_cnt to 0; in_ready SHALL be 1 after reset.
REQ-025 SHALL discard any in-flight packet when reset occurs mid-packet; the first byte after reset is treated as offset 0.

Verification
REQ-026 SHALL pass: in_sop with dmac_en=1, act_dmac=0x0A0B0C0D0E0F, then a 64-byte packet -> out bytes 0-5 = 0A..0F, others unchanged, out_last on byte 63, latency 2, stat_rewr_cnt=1.
REQ-027 SHALL pass: IPv4 packet, TTL 0x40, checksum 0xB1E6, ttl_dec=1 -> TTL 0x3F, checksum 0xB2E6.
REQ-028 SHALL pass: checksum 0xFFFF with ttl_dec=1 -> 0x0100; checksum 0xFF12 -> 0x0013; TTL 0x00 -> unchanged, stat_rewr_cnt not incremented.
REQ-029 SHALL pass: out_ready toggled randomly 50% during back-to-back 60-byte packets -> byte-exact output, no loss, out_* stable while stalled.
REQ-030 SHALL pass: a 23-byte packet with ttl_dec=1 -> TTL byte 22 decremented, no checksum write, out_last on byte 22, ofs=0 afterwards.
REQ-031 SHALL pass: rst_n asserted at byte 30 of 64 -> out_valid=0 immediately; the next packet is rewritten correctly from offset 0.
